sdram_write_ctrl: RTL and testbench



---
 rtl/sdram_write_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sdram_write_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_write_ctrl.sv
// sdram_write_ctrl
//   SDRAM write-burst controller. A trigger latches a burst count; the block
//   arbitrates for the command bus, opens a row (ACTIVE), streams back-to-back
//   WRITE bursts and closes the row (PRECHARGE). Column/row/bank pointers
//   advance automatically and persist between transfers. A refresh request
//   seen on the last beat of a burst closes the row, releases the bus and
//   re-arbitrates, resuming at the next address.
//
// Ports
//   sysclk_100M      system clock (rising edge)
//   rst              asynchronous active-high reset
//   write_trig       start request, sampled only in IDLE
//   wr_bursts        bursts to write (0 behaves as 1)
//   refresh_req      refresh pending, acted on at burst boundaries
//   arbit_write_req  command-bus request to the arbiter
//   arbit_write_ack  command-bus grant
//   arbit_prech_end  1-cycle pulse after each precharge completes
//   write_end        1-cycle pulse when the whole transfer is done
//   busy             high while not IDLE
//   data_vld         high on every data beat
//   cmd_reg          {CS_n,RAS_n,CAS_n,WE_n}
//   sdram_addr       row (ACTIVE) / column (WRITE) address
//   sdram_bank_addr  bank of the open row
//   bank_switch      1-cycle pulse when the bank pointer advances
module sdram_write_ctrl #(
   parameter int ROW_W     = 13,
   parameter int COL_W     = 9,
   parameter int BANK_W    = 2,
   parameter int BURST_LEN = 4,
   parameter int ROW_END   = 8192,
   parameter int T_RCD     = 2,
   parameter int T_RP      = 2,
   parameter int BANK_MODE = 0,
   parameter int CNT_W     = 16
) (
   input  logic              sysclk_100M,
   input  logic              rst,
   input  logic              write_trig,
   input  logic [CNT_W-1:0]  wr_bursts,
   input  logic              refresh_req,
   output logic              arbit_write_req,
   input  logic              arbit_write_ack,
   output logic              arbit_prech_end,
   output logic              write_end,
   output logic              busy,
   output logic              data_vld,
   output logic [3:0]        cmd_reg,
   output logic [ROW_W-1:0]  sdram_addr,
   output logic [BANK_W-1:0] sdram_bank_addr,
   output logic              bank_switch
);

   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_NOP = 4'b0111;

   // One shared down-the-line counter serves ACT wait, beat index and PRECHG wait.
   localparam int MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int MAXC  = (MAX_A > BURST_LEN) ? MAX_A : BURST_LEN;
   localparam int CW    = $clog2(MAXC + 1);
   localparam logic BANK_ADV = (BANK_MODE != 0);

   typedef enum logic [2:0] {IDLE, REQ, ACT, WRITE, PRECHG} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [CNT_W-1:0]  remaining;
   logic [COL_W-1:0]  col_ptr;
   logic [ROW_W-1:0]  row_ptr;
   logic [BANK_W-1:0] bank_ptr;
   logic              ref_pend;

   logic              last_beat;
   logic [COL_W-1:0]  col_next;
   logic              col_wrap;
   logic              row_last;
   logic [BANK_W-1:0] bank_next;

   always_comb begin
      last_beat = (cnt == CW'(BURST_LEN - 1));
      col_next  = col_ptr + COL_W'(BURST_LEN);
      col_wrap  = (col_next == '0);
      row_last  = (row_ptr == ROW_W'(ROW_END - 1));
      case (BANK_MODE)
         1:       bank_next = bank_ptr + BANK_W'(1);
         2:       bank_next = bank_ptr + BANK_W'(2);
         default: bank_next = bank_ptr;
      endcase
   end

   always_ff @(posedge sysclk_100M or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         remaining       <= '0;
         col_ptr         <= '0;
         row_ptr         <= '0;
         bank_ptr        <= '0;
         ref_pend        <= 1'b0;
         arbit_write_req <= 1'b0;
         arbit_prech_end <= 1'b0;
         write_end       <= 1'b0;
         busy            <= 1'b0;
         data_vld        <= 1'b0;
         cmd_reg         <= CMD_NOP;
         sdram_addr      <= '0;
         sdram_bank_addr <= '0;
         bank_switch     <= 1'b0;
      end else begin
         arbit_prech_end <= 1'b0;
         write_end       <= 1'b0;
         bank_switch     <= 1'b0;
         data_vld        <= 1'b0;
         cmd_reg         <= CMD_NOP;
         case (state)
            IDLE: begin
               if (write_trig) begin
                  remaining <= (wr_bursts == '0) ? CNT_W'(1) : wr_bursts;
                  busy      <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               arbit_write_req <= !arbit_write_ack;
               if (arbit_write_ack) begin
                  cnt   <= '0;
                  state <= ACT;
               end
            end
            ACT: begin
               cmd_reg         <= (cnt == '0) ? CMD_ACT : CMD_NOP;
               sdram_addr      <= row_ptr;
               // Bank output is only refreshed when a row is opened so that
               // the closing PRECHARGE targets the same bank even if the
               // pointer advanced on the last beat.
               sdram_bank_addr <= bank_ptr;
               if (cnt == CW'(T_RCD - 1)) begin
                  cnt   <= '0;
                  state <= WRITE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WRITE: begin
               cmd_reg    <= (cnt == '0) ? CMD_WR : CMD_NOP;
               sdram_addr <= ROW_W'(col_ptr + COL_W'(cnt));
               data_vld   <= 1'b1;
               if (last_beat) begin
                  cnt       <= '0;
                  remaining <= remaining - CNT_W'(1);
                  col_ptr   <= col_next;
                  if (col_wrap) begin
                     if (row_last) begin
                        row_ptr     <= '0;
                        bank_ptr    <= bank_next;
                        bank_switch <= BANK_ADV;
                     end else begin
                        row_ptr <= row_ptr + ROW_W'(1);
                     end
                  end
                  ref_pend <= refresh_req;
                  if (remaining == CNT_W'(1) || refresh_req || col_wrap)
                     state <= PRECHG;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PRECHG: begin
               cmd_reg    <= (cnt == '0) ? CMD_PRE : CMD_NOP;
               sdram_addr <= '0;  // A10 low: single-bank precharge
               if (cnt == CW'(T_RP - 1)) begin
                  cnt             <= '0;
                  arbit_prech_end <= 1'b1;
                  if (remaining == '0) begin
                     write_end <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else if (ref_pend) begin
                     state <= REQ;
                  end else begin
                     state <= ACT;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_write_ctrl.sv
// Testbench for sdram_write_ctrl. A transaction-level model predicts the
// ordered command stream (ACTIVE/WRITE/PRECHARGE with address and bank), the
// data-beat column sequence and pulse counts from linear burst arithmetic;
// a negedge monitor records what the DUT drives.
module tb_sdram_write_ctrl;
   localparam int BL     = 4;
   localparam int NCOL   = 512;
   localparam int REND   = 2;
   localparam int TRCD   = 2;
   localparam int TRP    = 2;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_NOP = 4'b0111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic write_trig = 1'b0;
   logic [15:0] wr_bursts = '0;
   logic refresh_req = 1'b0;
   logic arbit_write_ack = 1'b0;

   logic req, pend, wend, busy, vld, bsw;
   logic [3:0] cmd;
   logic [12:0] addr;
   logic [1:0] bank;
   logic req0, pend0, wend0, busy0, vld0, bsw0;
   logic [3:0] cmd0;
   logic [12:0] addr0;
   logic [1:0] bank0;

   always #5 clk = ~clk;

   sdram_write_ctrl #(.ROW_W(13), .COL_W(9), .BANK_W(2), .BURST_LEN(BL), .ROW_END(REND),
      .T_RCD(TRCD), .T_RP(TRP), .BANK_MODE(2), .CNT_W(16)) dut (
      .sysclk_100M(clk), .rst(rst), .write_trig(write_trig), .wr_bursts(wr_bursts),
      .refresh_req(refresh_req), .arbit_write_req(req), .arbit_write_ack(arbit_write_ack),
      .arbit_prech_end(pend), .write_end(wend), .busy(busy), .data_vld(vld),
      .cmd_reg(cmd), .sdram_addr(addr), .sdram_bank_addr(bank), .bank_switch(bsw));

   sdram_write_ctrl #(.ROW_W(13), .COL_W(9), .BANK_W(2), .BURST_LEN(BL), .ROW_END(REND),
      .T_RCD(TRCD), .T_RP(TRP), .BANK_MODE(0), .CNT_W(16)) dut0 (
      .sysclk_100M(clk), .rst(rst), .write_trig(write_trig), .wr_bursts(wr_bursts),
      .refresh_req(refresh_req), .arbit_write_req(req0), .arbit_write_ack(arbit_write_ack),
      .arbit_prech_end(pend0), .write_end(wend0), .busy(busy0), .data_vld(vld0),
      .cmd_reg(cmd0), .sdram_addr(addr0), .sdram_bank_addr(bank0), .bank_switch(bsw0));

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ev(input logic [3:0] c, input int a, input int b);
      return (int'(c) << 16) | (a << 2) | (b & 3);
   endfunction

   // ---------------- monitor ----------------
   int obs_ev[$];
   int obs_cyc[$];
   int obs_beat[$];
   int n_wr = 0, n_wend = 0, n_pend = 0, n_req = 0, n_bsw = 0, n_bsw0 = 0, n_diff0 = 0;
   int wend_cyc = 0, pend_cyc = 0;
   logic prev_req = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd != C_NOP) begin
            obs_ev.push_back(ev(cmd, int'(addr), int'(bank)));
            obs_cyc.push_back(cyc);
            if (cmd == C_WR) n_wr = n_wr + 1;
         end
         if (vld) obs_beat.push_back(int'(addr));
         if (wend) begin n_wend = n_wend + 1; wend_cyc = cyc; end
         if (pend) begin n_pend = n_pend + 1; pend_cyc = cyc; end
         if (req && !prev_req) n_req = n_req + 1;
         prev_req = req;
         if (bsw) n_bsw = n_bsw + 1;
         if (bsw0) n_bsw0 = n_bsw0 + 1;
         // Bank mode must not change timing or addressing of the second instance.
         if ({req0, pend0, wend0, busy0, vld0, cmd0, addr0} !== {req, pend, wend, busy, vld, cmd, addr})
            n_diff0 = n_diff0 + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int g = 0;  // bursts written since reset (linear address / BL)
   int exp_ev[$];
   int exp_beat[$];
   int exp_req, exp_pre, exp_bsw;

   function automatic int col_of(input int p);  return (p * BL) % NCOL; endfunction
   function automatic int row_of(input int p);  return ((p * BL) / NCOL) % REND; endfunction
   function automatic int bank_of(input int p); return (((p * BL) / (NCOL * REND)) * 2) % 4; endfunction

   task automatic model_xfer(input int n_in, input int refk);
      int n, ab;
      n = (n_in == 0) ? 1 : n_in;
      exp_ev.delete(); exp_beat.delete();
      exp_req = 1; exp_pre = 0; exp_bsw = 0;
      ab = bank_of(g);
      exp_ev.push_back(ev(C_ACT, row_of(g), ab));
      for (int i = 1; i <= n; i++) begin
         exp_ev.push_back(ev(C_WR, col_of(g), ab));
         for (int j = 0; j < BL; j++) exp_beat.push_back(col_of(g) + j);
         g++;
         if ((g * BL) % (NCOL * REND) == 0) exp_bsw++;
         if (i == n || i == refk || col_of(g) == 0) begin
            exp_ev.push_back(ev(C_PRE, 0, ab));
            exp_pre++;
            if (i == n) break;
            if (i == refk) exp_req++;
            ab = bank_of(g);
            exp_ev.push_back(ev(C_ACT, row_of(g), ab));
         end
      end
   endtask

   // ---------------- transfer driver + check ----------------
   int b_ev, b_beat, b_wr, b_wend, b_pend, b_req, b_bsw, b_bsw0;

   task automatic snap();
      b_ev = obs_ev.size(); b_beat = obs_beat.size(); b_wr = n_wr; b_wend = n_wend;
      b_pend = n_pend; b_req = n_req; b_bsw = n_bsw; b_bsw0 = n_bsw0;
   endtask

   task automatic run_xfer(input string tag, input int n, input int refk, input int ackd, input bit poke);
      int wc, budget, e0;
      bit refd, fin;
      snap();
      model_xfer(n, refk);
      @(negedge clk); #1;
      write_trig = 1'b1; wr_bursts = 16'(n);
      @(negedge clk); #1;
      write_trig = 1'b0;
      wc = 0; refd = 0; fin = 0;
      budget = (n + 1) * BL * 3 + 200;
      for (int k = 0; k < budget && !fin; k++) begin
         @(negedge clk); #1;
         if (req && !arbit_write_ack) begin
            if (wc >= ackd) arbit_write_ack = 1'b1; else wc++;
         end else begin
            arbit_write_ack = 1'b0; wc = 0;
         end
         if (refk > 0 && !refd && (n_wr - b_wr) >= refk) begin
            refresh_req = 1'b1; refd = 1;
         end else if (refresh_req && req) begin
            refresh_req = 1'b0;
         end
         write_trig = poke && ((n_wr - b_wr) == 1);
         if (n_wend > b_wend) fin = 1;
      end
      write_trig = 1'b0; refresh_req = 1'b0; arbit_write_ack = 1'b0;
      chk({tag, ":finish"}, int'(fin), 1);
      chk({tag, ":busy_end"}, int'(busy), 0);
      chk({tag, ":pend_with_wend"}, pend_cyc, wend_cyc);
      repeat (3) @(negedge clk);
      #1;
      chk({tag, ":n_cmd"}, obs_ev.size() - b_ev, exp_ev.size());
      e0 = errors;
      for (int i = 0; i < exp_ev.size() && errors == e0; i++)
         if (b_ev + i < obs_ev.size()) chk({tag, ":cmd"}, obs_ev[b_ev + i], exp_ev[i]);
      chk({tag, ":n_beat"}, obs_beat.size() - b_beat, exp_beat.size());
      e0 = errors;
      for (int i = 0; i < exp_beat.size() && errors == e0; i++)
         if (b_beat + i < obs_beat.size()) chk({tag, ":beat"}, obs_beat[b_beat + i], exp_beat[i]);
      chk({tag, ":wend_cnt"}, n_wend - b_wend, 1);
      chk({tag, ":pend_cnt"}, n_pend - b_pend, exp_pre);
      chk({tag, ":req_cnt"}, n_req - b_req, exp_req);
      chk({tag, ":bsw_cnt"}, n_bsw - b_bsw, exp_bsw);
      chk({tag, ":inst0_same"}, n_diff0, 0);
   endtask

   initial begin
      int n, rk, ad;
      bit done;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst:req", int'(req), 0);
      chk("rst:pend", int'(pend), 0);
      chk("rst:wend", int'(wend), 0);
      chk("rst:busy", int'(busy), 0);
      chk("rst:vld", int'(vld), 0);
      chk("rst:bsw", int'(bsw), 0);
      chk("rst:cmd", int'(cmd), int'(C_NOP));
      chk("rst:addr", int'(addr), 0);
      chk("rst:bank", int'(bank), 0);
      #1 rst = 1'b0;

      // three bursts, ack after 2 cycles: exact command spacing
      run_xfer("basic", 3, 0, 2, 0);
      if (obs_cyc.size() >= b_ev + 5) begin
         chk("basic:t_rcd", obs_cyc[b_ev + 1] - obs_cyc[b_ev], TRCD);
         chk("basic:wr_gap1", obs_cyc[b_ev + 2] - obs_cyc[b_ev + 1], BL);
         chk("basic:wr_gap2", obs_cyc[b_ev + 3] - obs_cyc[b_ev + 2], BL);
         chk("basic:pre_gap", obs_cyc[b_ev + 4] - obs_cyc[b_ev + 3], BL);
         chk("basic:wend_lat", wend_cyc - obs_cyc[b_ev + 4], TRP - 1);
      end else begin
         chk("basic:cmd_present", obs_cyc.size() - b_ev, 5);
      end

      run_xfer("zero_cnt", 0, 0, 0, 0);    // behaves as one burst
      run_xfer("fill", 122, 0, 1, 1);      // advance to column 504, trigger poked mid-transfer
      run_xfer("row_end", 4, 0, 3, 0);     // 504,508 | PRE | ACT row 1 | 0,4
      run_xfer("refresh", 5, 2, 1, 0);     // refresh after burst 2, resume
      run_xfer("bank_wrap", 125, 0, 0, 0); // crosses last row -> bank 0 to 2
      chk("bank_wrap:mode0_bank", int'(bank0), 0);
      chk("bank_wrap:mode0_bsw", n_bsw0 - b_bsw0, 0);

      for (int t = 0; t < 4; t++) begin
         n  = int'($urandom_range(1, 20));
         rk = int'($urandom_range(0, n - 1));
         ad = int'($urandom_range(0, 3));
         run_xfer("rand", n, rk, ad, 1'($urandom & 1));
      end

      // reset while in WRITE beat 2
      snap();
      @(negedge clk); #1;
      write_trig = 1'b1; wr_bursts = 16'd5;
      @(negedge clk); #1;
      write_trig = 1'b0;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk); #1;
         arbit_write_ack = req && !arbit_write_ack;
         if (n_wr > b_wr) done = 1;
      end
      arbit_write_ack = 1'b0;
      chk("abort:reached_write", int'(done), 1);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort:busy", int'(busy), 0);
      chk("abort:cmd", int'(cmd), int'(C_NOP));
      chk("abort:vld", int'(vld), 0);
      chk("abort:addr", int'(addr), 0);
      chk("abort:bank", int'(bank), 0);
      chk("abort:req", int'(req), 0);
      g = 0;
      @(negedge clk); #1;
      rst = 1'b0;
      prev_req = 1'b0;
      run_xfer("after_rst", 1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
